// File: rtl/vchk_pkg.sv
// vchk_pkg: shared types and helpers for the vector_checker sequencer.
//   vchk_state_t   : sequencer states
//   vchk_popcount  : number of set bits in a pass-flag vector (up to VCHK_MAX_CH)
package vchk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    WAIT,
    CHECK,
    DONE
  } vchk_state_t;

  // Widest pass-flag vector the popcount helper accepts.
  localparam int unsigned VCHK_MAX_CH = 32;

  function automatic int unsigned vchk_popcount(input logic [VCHK_MAX_CH-1:0] bits);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < VCHK_MAX_CH; i++) begin
      n += 32'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/vchk_lane.sv
// vchk_lane: masked compare of one result channel.
//   expected : answer word
//   actual   : DUT result word
//   mask     : 1 = bit is checked
//   pass     : 1 when no checked bit differs
module vchk_lane #(
  parameter int unsigned RES_W = 34
) (
  input  logic [RES_W-1:0] expected,
  input  logic [RES_W-1:0] actual,
  input  logic [RES_W-1:0] mask,
  output logic             pass
);

  always_comb begin
    pass = (((expected ^ actual) & mask) == '0);
  end

endmodule

// File: rtl/vector_checker.sv
// vector_checker: steps a test index through a vector memory, waits LAT
// cycles for the unit under test, then compares N_CH masked channels and
// accumulates pass/fail counts plus the first failure.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a run (accepted in IDLE or DONE)
//   cmp_mask            : per-channel compare mask, latched on start
//   expected, actual    : answer and result words for the current idx
//   idx, vec_req        : ROM address and one-cycle test-start pulse
//   busy, done          : run in progress / run complete
//   pass_cnt, fail_cnt  : channel-check scores
//   first_fail_*        : first failing vector and its lowest failing channel
module vector_checker
  import vchk_pkg::*;
#(
  parameter int unsigned RES_W     = 34,
  parameter int unsigned N_CH      = 2,
  parameter int unsigned NUM_TESTS = 70,
  parameter int unsigned LAT       = 1,
  parameter int unsigned IDX_W     = $clog2(NUM_TESTS),
  parameter int unsigned SC_W      = $clog2(NUM_TESTS*N_CH+1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [N_CH*RES_W-1:0]                 cmp_mask,
  input  logic [N_CH*RES_W-1:0]                 expected,
  input  logic [N_CH*RES_W-1:0]                 actual,
  output logic [IDX_W-1:0]                      idx,
  output logic                                  vec_req,
  output logic                                  busy,
  output logic                                  done,
  output logic [SC_W-1:0]                       pass_cnt,
  output logic [SC_W-1:0]                       fail_cnt,
  output logic                                  first_fail_vld,
  output logic [IDX_W-1:0]                      first_fail_idx,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_fail_ch
);

  localparam int unsigned FC_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned WT_W = (LAT > 1) ? $clog2(LAT) : 1;

  vchk_state_t             state;
  logic [WT_W-1:0]         wait_cnt;
  logic [N_CH*RES_W-1:0]   mask_q;
  logic [N_CH-1:0]         lane_pass;
  logic [SC_W-1:0]         n_pass;
  logic [FC_W-1:0]         low_fail;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    vchk_lane #(.RES_W(RES_W)) u_lane (
      .expected (expected[c*RES_W +: RES_W]),
      .actual   (actual[c*RES_W +: RES_W]),
      .mask     (mask_q[c*RES_W +: RES_W]),
      .pass     (lane_pass[c])
    );
  end

  always_comb begin
    n_pass = SC_W'(vchk_popcount(VCHK_MAX_CH'(lane_pass)));
  end

  // Ascending scan with a found flag keeps the lowest failing channel.
  always_comb begin
    logic found;
    low_fail = '0;
    found    = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (!lane_pass[c] && !found) begin
        low_fail = FC_W'(c);
        found    = 1'b1;
      end
    end
  end

  // vec_req/busy/done are registered: each is set on the edge that enters
  // the state in which it must be high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      idx            <= '0;
      wait_cnt       <= '0;
      mask_q         <= '0;
      vec_req        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_vld <= 1'b0;
      first_fail_idx <= '0;
      first_fail_ch  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx            <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            first_fail_ch  <= '0;
            mask_q         <= cmp_mask;
            vec_req        <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            state          <= APPLY;
          end
        end
        APPLY: begin
          vec_req  <= 1'b0;
          wait_cnt <= WT_W'(LAT - 1);
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        CHECK: begin
          pass_cnt <= pass_cnt + n_pass;
          fail_cnt <= fail_cnt + (SC_W'(N_CH) - n_pass);
          if ((lane_pass != '1) && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx;
            first_fail_ch  <= low_fail;
          end
          if (idx == IDX_W'(NUM_TESTS - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx     <= idx + 1'b1;
            vec_req <= 1'b1;
            state   <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vector_checker.md
# vector_checker

Synthesizable self-checking sequencer for the datapath unit benches: it steps a test index through a vector memory, waits a programmable DUT latency, and then compares N_CH result channels against expected words under a per-channel bit mask. It accumulates pass and fail counts and records the first failure. It sits between the vector/answer ROMs and the combinational or pipelined units under test (ALU, shifter, and their successors), and is clocked alongside the DUT.

## Interface
Parameters:
- RES_W, 34: width of one channel's result word (for the ALU: {overflow, zero, result[31:0]}).
- N_CH, 2: number of checked channels.
- NUM_TESTS, 70: number of vectors, numbered 0..NUM_TESTS-1.
- LAT, 1: DUT latency in cycles from `vec_req` to a valid result; must be at least 1.
- IDX_W, $clog2(NUM_TESTS): width of the test index.
- SC_W, $clog2(NUM_TESTS*N_CH+1): width of the score counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; honoured only in IDLE or DONE.
- cmp_mask  in  N_CH*RES_W  per-channel compare mask, 1 = bit checked; sampled on an accepted start.
- expected  in  N_CH*RES_W  answer words for the current `idx`; channel c occupies bits [c*RES_W +: RES_W].
- actual  in  N_CH*RES_W  DUT outputs, using the same packing.
- idx  out  IDX_W  current vector index, driven to the ROM address.
- vec_req  out  1  one-cycle pulse marking the start of a test.
- busy  out  1  high in APPLY, WAIT and CHECK.
- done  out  1  high in DONE.
- pass_cnt  out  SC_W  number of passing channel checks.
- fail_cnt  out  SC_W  number of failing channel checks.
- first_fail_vld  out  1  set when at least one failure has been recorded.
- first_fail_idx  out  IDX_W  index of the first failing vector.
- first_fail_ch  out  $clog2(N_CH) (minimum 1)  lowest-numbered failing channel of that vector.

## Operation
- States: IDLE, APPLY, WAIT, CHECK, DONE.
- IDLE, or DONE, with `start` = 1:
  - clear `idx`, both counters and all first_fail_* outputs;
  - latch `cmp_mask`;
  - go to APPLY.
- APPLY:
  - `vec_req` = 1;
  - load the wait counter with LAT-1;
  - go to WAIT.
- WAIT:
  - decrement the wait counter;
  - go to CHECK in the cycle the counter reads 0.
- CHECK: for each channel c, the channel passes iff ((expected_c ^ actual_c) & mask_c) == 0.
  - pass_cnt increases by the number of passing channels in one cycle; fail_cnt increases by N_CH minus that number.
  - If any channel fails and first_fail_vld = 0: set first_fail_vld, capture `idx`, and capture the lowest failing channel.
  - If idx == NUM_TESTS-1: go to DONE, and `idx` holds its value. Otherwise increment `idx` and go to APPLY.
- DONE:
  - outputs hold;
  - `start` restarts the run;
  - invariant: pass_cnt + fail_cnt == NUM_TESTS*N_CH.
- `start` in APPLY, WAIT or CHECK is ignored.
- Counters cannot overflow; SC_W is sized for the maximum count.

## Timing
- Reset values: state = IDLE; idx = 0; vec_req = 0; busy = 0; done = 0; pass_cnt = fail_cnt = 0; first_fail_* = 0.
- Reset asserted mid-run aborts the run immediately with no final compare, and takes priority over start.
- One test takes LAT+2 cycles: APPLY, then LAT cycles of WAIT, then CHECK.
- `expected` and `actual` are sampled on the CHECK rising edge.
- `idx` is stable from APPLY through CHECK inclusive. The ROM may therefore use a registered read.
- With LAT=1, WAIT lasts exactly one cycle.
- A start accepted on edge k gives APPLY in cycle k+1.
- `done` rises one cycle after the final CHECK.
- A full run takes NUM_TESTS*(LAT+2) cycles from APPLY to DONE.

## Structure
- Package vchk_pkg:
  - state enum vchk_state_t (IDLE, APPLY, WAIT, CHECK, DONE);
  - a popcount helper function for N_CH pass bits.
- Sub-module vchk_lane:
  - one instance per channel via generate;
  - inputs: expected, actual, mask;
  - output: a 1-bit pass flag.
- Top level holds the FSM, the wait counter, the index register, the score counters and the first-fail capture.

## Test plan
All scenarios use NUM_TESTS=4, N_CH=2, LAT=1 unless stated otherwise.
- All match: actual = expected for every vector, mask all-ones -> done after 12 cycles, pass_cnt=8, fail_cnt=0, first_fail_vld=0.
- Single miss: vector 2, channel 1 differs in bit 5 -> pass_cnt=7, fail_cnt=1, first_fail_idx=2, first_fail_ch=1.
- Mask hides a difference: channel 1 mask = 34'h0_FFFF_FFFF, vector 0 has channel 1 bits 33:32 flipped -> pass_cnt=8.
- Both channels fail on vector 0, channel 0 also fails on vector 3 -> fail_cnt=3, first_fail_idx=0, first_fail_ch=0.
- LAT=3: vec_req pulses exactly every 5 cycles, idx advances 0..3, and done rises 20 cycles after the first APPLY.
- Reset in cycle 6 of a run, then start -> all outputs zero after reset; the re-run gives pass_cnt=8. A start pulsed during WAIT has no effect.
